// File: rtl/anemometer_freq_meter.sv
// Anemometer pulse-rate front-end.
// The raw pulse input is synchronised, glitch-filtered and edge-detected.
// Rising edges are then counted over a fixed gate window. The saturated count
// and a valid flag are published in continuous or single-shot mode.
module anemometer_freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_freq_anemometre,
    input  logic                  continu,
    input  logic                  start_stop,
    output logic [DATA_WIDTH-1:0] data_anemometre,
    output logic                  data_valid
);

    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int unsigned CW = DATA_WIDTH + 1;

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX   = {1'b0, {DATA_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } state_t;

    // Input conditioning
    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          filt_prev_q;
    logic          edge_pulse;

    // Measurement
    state_t                state_q;
    logic [GW-1:0]         gate_q;
    logic [CW-1:0]         ecnt_q;
    logic [CW-1:0]         ecnt_inc;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Two-flop synchroniser for the asynchronous pulse input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], in_freq_anemometre};
        end
    end

    // Glitch filter: a level change is accepted after FILTER_LEN consecutive
    // differing samples; any matching sample restarts the run.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state and previous filtered level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q      <= 1'b0;
            fcnt_q      <= '0;
            filt_prev_q <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            filt_prev_q <= filt_q;
        end
    end

    assign edge_pulse = filt_q & ~filt_prev_q;

    // Saturating edge-count increment; includes an edge on the closing cycle
    always_comb begin
        ecnt_inc = ecnt_q;
        if (edge_pulse && (ecnt_q != CNT_MAX)) begin
            ecnt_inc = ecnt_q + 1'b1;
        end
    end

    // Gate/measurement FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gate_q  <= '0;
            ecnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gate_q <= '0;
                    ecnt_q <= '0;
                    if (continu || start_stop) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (gate_q == GATE_LAST) begin
                        data_q  <= ecnt_inc[DATA_WIDTH-1:0];
                        valid_q <= 1'b1;
                        gate_q  <= '0;
                        ecnt_q  <= '0;
                        // Back-to-back windows in continuous mode, no dead cycle
                        state_q <= continu ? MEASURE : DONE;
                    end else begin
                        gate_q <= gate_q + 1'b1;
                        ecnt_q <= ecnt_inc;
                    end
                end
                DONE: begin
                    if (continu) begin
                        state_q <= MEASURE;
                    end else if (!start_stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_anemometre = data_q;
    assign data_valid      = valid_q;

endmodule

// File: tb/tb_anemometer_freq_meter.sv
// Directed bench for anemometer_freq_meter: continuous, glitch rejection,
// saturation, single-shot handshake, mode switch and asynchronous reset.
module tb_anemometer_freq_meter;

    logic       clk;
    logic       reset;
    logic       pin;
    logic       pin_sat;
    logic       continu;
    logic       start_stop;
    logic [7:0] data;
    logic       valid;
    logic [7:0] data_sat;
    logic       valid_sat;

    int n_chk  = 0;
    int n_pass = 0;

    // Wave generator control (written only by the main process)
    int wave_t0 = 0;
    int period  = 20;
    int hi      = 10;
    int cyc     = 0;

    anemometer_freq_meter #(
        .GATE_CYCLES(1000),
        .FILTER_LEN (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_freq_anemometre(pin),
        .continu           (continu),
        .start_stop        (start_stop),
        .data_anemometre   (data),
        .data_valid        (valid)
    );

    anemometer_freq_meter #(
        .GATE_CYCLES(4000),
        .FILTER_LEN (4),
        .DATA_WIDTH (8)
    ) dut_sat (
        .clk               (clk),
        .reset             (reset),
        .in_freq_anemometre(pin_sat),
        .continu           (continu),
        .start_stop        (start_stop),
        .data_anemometre   (data_sat),
        .data_valid        (valid_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square waves, low phase first: high while phase >= period-hi
    initial begin
        pin     = 1'b0;
        pin_sat = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            cyc     = cyc + 1;
            pin     = (((cyc - wave_t0) % period) >= (period - hi));
            pin_sat = ((cyc % 10) >= 5);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Bounded wait for data_valid; returns cycles taken (max on timeout)
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (valid) break;
        end
    endtask

    int n;

    initial begin
        reset      = 1'b1;
        continu    = 1'b0;
        start_stop = 1'b0;
        ticks(3);
        check_eq("rst_data", data, 0);
        check_eq("rst_valid", valid, 0);

        // Continuous mode, period 20
        continu = 1'b1;
        @(negedge clk);
        period  = 20;
        hi      = 10;
        wave_t0 = cyc;
        reset   = 1'b0;
        for (int k = 1; k <= 8001; k++) begin
            tick();
            if (k == 1000) check_eq("cont_valid_pre", valid, 0);
            if (k == 1001) check_eq("cont_valid_rise", valid, 1);
            if (k == 1500) check_eq("cont_valid_hold", valid, 1);
            if (k > 1 && (k % 1000) == 1) check_eq("cont_data", data, 50);
            if (k == 4000) check_eq("sat_valid_pre", valid_sat, 0);
            if (k == 4001) check_eq("sat_valid", valid_sat, 1);
            if (k == 4001 || k == 8001) check_eq("sat_data", data_sat, 255);
        end

        // Asynchronous reset mid-window
        ticks(500);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("amid_data", data, 0);
        check_eq("amid_valid", valid, 0);
        ticks(2);
        @(negedge clk);
        wave_t0 = cyc;
        reset   = 1'b0;
        for (int k = 1; k <= 1001; k++) begin
            tick();
            if (k == 1000) check_eq("rrel_valid_pre", valid, 0);
            if (k == 1001) begin
                check_eq("rrel_valid", valid, 1);
                check_eq("rrel_data", data, 50);
            end
        end

        // Glitch rejection: 3-cycle pulses never pass the filter
        hi = 3;
        for (int k = 1002; k <= 4001; k++) begin
            tick();
            if (k == 3001 || k == 4001) begin
                check_eq("glitch_data", data, 0);
                check_eq("glitch_valid", valid, 1);
            end
        end

        // Single-shot handshake, period 40
        @(negedge clk);
        reset      = 1'b1;
        continu    = 1'b0;
        start_stop = 1'b0;
        period     = 40;
        hi         = 20;
        ticks(2);
        @(negedge clk);
        reset = 1'b0;
        ticks(50);
        check_eq("ss_idle_valid", valid, 0);
        check_eq("ss_idle_data", data, 0);
        @(negedge clk);
        start_stop = 1'b1;
        wave_t0    = cyc;
        wait_valid(1200, n);
        check_eq("ss_latency", n, 1001);
        check_eq("ss_data", data, 25);
        ticks(200);
        check_eq("ss_hold_valid", valid, 1);
        check_eq("ss_hold_data", data, 25);
        @(negedge clk);
        start_stop = 1'b0;
        tick();
        check_eq("ss_drop_valid", valid, 0);
        check_eq("ss_drop_data", data, 25);
        ticks(1100);
        check_eq("ss_nostart_valid", valid, 0);
        @(negedge clk);
        start_stop = 1'b1;
        wave_t0    = cyc;
        wait_valid(1200, n);
        check_eq("ss2_latency", n, 1001);
        check_eq("ss2_data", data, 25);
        @(negedge clk);
        start_stop = 1'b0;
        tick();
        check_eq("ss2_drop_valid", valid, 0);

        // Mode switch: continuous -> single-shot mid-window
        @(negedge clk);
        continu = 1'b1;
        period  = 20;
        hi      = 10;
        wave_t0 = cyc;
        wait_valid(1200, n);
        check_eq("ms_latency", n, 1001);
        ticks(500);
        @(negedge clk);
        continu = 1'b0;
        ticks(500);
        check_eq("ms_end_data", data, 50);
        check_eq("ms_end_valid", valid, 1);
        tick();
        check_eq("ms_idle_valid", valid, 0);
        check_eq("ms_idle_data", data, 50);
        ticks(200);
        check_eq("ms_stay_valid", valid, 0);
        check_eq("ms_stay_data", data, 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
